// File: rtl/spi_fpu_pkg.sv
// Shared types, opcode constants and opcode classification for the SPI-to-FPU command path.
package spi_fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_WAIT,
        ST_SEND,
        ST_ERROR
    } state_e;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_MUL  = 8'd2;
    localparam logic [7:0] OP_DIV  = 8'd3;
    localparam logic [7:0] OP_SQRT = 8'd4;
    localparam logic [7:0] OP_NEG  = 8'd5;

    localparam logic [7:0] STATUS_READY = 8'h80;
    localparam logic [7:0] STATUS_ERR   = 8'hEE;

    // Opcodes arrive zero-extended to a byte so the helpers are independent of OP_W.
    function automatic logic is_unary(input logic [7:0] op);
        return (op == OP_SQRT) || (op == OP_NEG);
    endfunction

    function automatic logic is_valid(input logic [7:0] op);
        return op <= OP_NEG;
    endfunction

endpackage

// File: rtl/spi_fpu_cmd_ctrl_if.sv
// Byte-shifter and FPU-side signals of the command sequencer, grouped for port connection.
interface spi_fpu_cmd_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
);
    logic             cs_active;
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             tx_ack;
    logic [7:0]       tx_byte;
    logic             fpu_start;
    logic             fpu_abort;
    logic [OP_W-1:0]  fpu_op;
    logic [WIDTH-1:0] fpu_a;
    logic [WIDTH-1:0] fpu_b;
    logic             fpu_done;
    logic [WIDTH-1:0] fpu_result;
    logic [4:0]       fpu_flags;
    logic             busy;

    modport master (
        output cs_active, rx_valid, rx_byte, tx_ack, fpu_done, fpu_result, fpu_flags,
        input  tx_byte, fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b, busy
    );

    modport slave (
        input  cs_active, rx_valid, rx_byte, tx_ack, fpu_done, fpu_result, fpu_flags,
        output tx_byte, fpu_start, fpu_abort, fpu_op, fpu_a, fpu_b, busy
    );
endinterface

// File: rtl/spi_fpu_byte_assembler.sv
// Shift-in register that assembles a WIDTH-bit operand from bytes, MSB first.
module spi_fpu_byte_assembler #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_c_o
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (clr_i) begin
            data_d = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (shift_i && !full_q) begin
            data_d = (data_q << 8) | WIDTH'(byte_i);
            cnt_d  = cnt_q + CNT_W'(1);
            full_d = (cnt_q == CNT_W'(NBYTES - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    // High while the next accepted byte completes the operand.
    assign last_c_o = !full_q && (cnt_q == CNT_W'(NBYTES - 1));
    assign data_o   = data_q;

endmodule

// File: rtl/spi_fpu_cmd_ctrl.sv
// Per-frame command sequencer: opcode decode, operand load, FPU handshake and result streaming.
module spi_fpu_cmd_ctrl
    import spi_fpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spi_fpu_cmd_ctrl_if.slave bus_if
);
    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

    state_e           state_q, state_d;
    logic [7:0]       tx_q, tx_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             unary_q, unary_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OP_W-1:0]  rx_op_c;
    logic             asm_clr_c, a_shift_c, b_shift_c, a_last_c, b_last_c;
    logic [WIDTH-1:0] a_data, b_data;

    assign rx_op_c   = bus_if.rx_byte[OP_W-1:0];
    assign asm_clr_c = (state_q == ST_IDLE);
    assign a_shift_c = bus_if.cs_active && bus_if.rx_valid && (state_q == ST_LOAD_A);
    assign b_shift_c = bus_if.cs_active && bus_if.rx_valid && (state_q == ST_LOAD_B);

    spi_fpu_byte_assembler #(.WIDTH(WIDTH)) u_asm_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (asm_clr_c),
        .shift_i  (a_shift_c),
        .byte_i   (bus_if.rx_byte),
        .data_o   (a_data),
        .last_c_o (a_last_c)
    );

    spi_fpu_byte_assembler #(.WIDTH(WIDTH)) u_asm_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (asm_clr_c),
        .shift_i  (b_shift_c),
        .byte_i   (bus_if.rx_byte),
        .data_o   (b_data),
        .last_c_o (b_last_c)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        abort_d = 1'b0;
        op_d    = op_q;
        unary_d = unary_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        // Chip-select release overrides every other event in the same cycle.
        if ((state_q != ST_IDLE) && !bus_if.cs_active) begin
            state_d = ST_IDLE;
            tx_d    = 8'h00;
            cnt_d   = '0;
            abort_d = (state_q == ST_START) || (state_q == ST_WAIT);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    tx_d  = 8'h00;
                    cnt_d = '0;
                    if (bus_if.cs_active) state_d = ST_OPCODE;
                end
                ST_OPCODE: begin
                    if (bus_if.rx_valid) begin
                        op_d = rx_op_c;
                        if (is_valid(8'(rx_op_c))) begin
                            unary_d = is_unary(8'(rx_op_c));
                            state_d = ST_LOAD_A;
                        end else begin
                            tx_d    = STATUS_ERR;
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_LOAD_A: begin
                    if (bus_if.rx_valid && a_last_c) state_d = unary_q ? ST_START : ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    if (bus_if.rx_valid && b_last_c) state_d = ST_START;
                end
                ST_START: state_d = ST_WAIT;
                ST_WAIT: begin
                    tx_d = 8'h00;
                    if (bus_if.fpu_done) begin
                        res_d   = bus_if.fpu_result;
                        tx_d    = STATUS_READY | {3'b000, bus_if.fpu_flags};
                        cnt_d   = '0;
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Result shifts out MSB first; once drained the counter saturates and 00 is sent.
                    if (bus_if.tx_ack) begin
                        if (cnt_q < CNT_W'(NBYTES)) begin
                            tx_d  = res_q[WIDTH-1 -: 8];
                            res_d = res_q << 8;
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            tx_d = 8'h00;
                        end
                    end
                end
                ST_ERROR: tx_d = STATUS_ERR;
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 8'h00;
                end
            endcase
        end

        start_d = (state_d == ST_START) && (state_q != ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'h00;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            unary_q <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            abort_q <= abort_d;
            busy_q  <= busy_d;
            unary_q <= unary_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_if.tx_byte   = tx_q;
    assign bus_if.fpu_start = start_q;
    assign bus_if.fpu_abort = abort_q;
    assign bus_if.fpu_op    = op_q;
    assign bus_if.fpu_a     = a_data;
    assign bus_if.fpu_b     = b_data;
    assign bus_if.busy      = busy_q;

endmodule

// File: tb/tb_spi_fpu_cmd_ctrl.sv
// Directed bench for spi_fpu_cmd_ctrl: table of full frames plus hand-written corner sequences.
module tb_spi_fpu_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   start_cnt = 0;
    int   abort_cnt = 0;

    always #5 clk = ~clk;

    spi_fpu_cmd_ctrl_if #(.WIDTH(32), .OP_W(4)) bus ();

    spi_fpu_cmd_ctrl #(.WIDTH(32), .OP_W(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    always @(posedge clk) begin
        if (bus.fpu_start) start_cnt <= start_cnt + 1;
        if (bus.fpu_abort) abort_cnt <= abort_cnt + 1;
    end

    typedef struct {
        logic [7:0]  opc;
        logic [3:0]  exp_op;
        logic        unary;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;
        logic [39:0] tx;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic ack();
        bus.tx_ack = 1'b1;
        tick();
        bus.tx_ack = 1'b0;
    endtask

    // Opens a frame and loads opcode plus operands; checks the start pulse right after the last byte.
    task automatic load_frame(input int i, input vec_t v);
        int s0;
        s0 = start_cnt;
        bus.cs_active = 1'b1;
        tick();
        send_byte(v.opc);
        for (int k = 0; k < 4; k++) send_byte(v.a[31-8*k -: 8]);
        if (!v.unary)
            for (int k = 0; k < 4; k++) send_byte(v.b[31-8*k -: 8]);
        check($sformatf("v%0d start", i), 64'(bus.fpu_start), 64'd1);
        check($sformatf("v%0d op", i), 64'(bus.fpu_op), 64'(v.exp_op));
        check($sformatf("v%0d a", i), 64'(bus.fpu_a), 64'(v.a));
        check($sformatf("v%0d b", i), 64'(bus.fpu_b), 64'(v.b));
        tick();
        check($sformatf("v%0d start_once", i), 64'(start_cnt - s0), 64'd1);
        check($sformatf("v%0d wait_tx", i), 64'(bus.tx_byte), 64'h00);
    endtask

    task automatic finish_frame(input int i, input vec_t v);
        tick();
        bus.fpu_done   = 1'b1;
        bus.fpu_result = v.res;
        bus.fpu_flags  = v.flags;
        tick();
        bus.fpu_done = 1'b0;
        check($sformatf("v%0d status", i), 64'(bus.tx_byte), 64'(v.tx[39:32]));
        for (int k = 1; k < 5; k++) begin
            ack();
            check($sformatf("v%0d tx%0d", i, k), 64'(bus.tx_byte), 64'(v.tx[39-8*k -: 8]));
        end
        ack();
        check($sformatf("v%0d drained", i), 64'(bus.tx_byte), 64'h00);
        check($sformatf("v%0d hold_busy", i), 64'(bus.busy), 64'd1);
        bus.cs_active = 1'b0;
        tick();
        check($sformatf("v%0d idle", i), 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int s0, a0;
        vecs[0] = '{8'h00, 4'd0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 5'h00, 40'h8040400000};
        vecs[1] = '{8'h04, 4'd4, 1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 5'h01, 40'h8140000000};
        vecs[2] = '{8'h02, 4'd2, 1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'h00, 40'h8040C00000};
        vecs[3] = '{8'h05, 4'd5, 1'b1, 32'h3F800000, 32'h00000000, 32'hBF800000, 5'h00, 40'h80BF800000};
        vecs[4] = '{8'h13, 4'd3, 1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 40'h887F800000};

        bus.cs_active  = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_byte    = 8'h00;
        bus.tx_ack     = 1'b0;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
        bus.fpu_flags  = '0;
        tick();
        tick();
        check("rst tx", 64'(bus.tx_byte), 64'h00);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst start", 64'(bus.fpu_start), 64'd0);
        check("rst a", 64'(bus.fpu_a), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            load_frame(i, vecs[i]);
            finish_frame(i, vecs[i]);
        end

        // Bad opcode: error byte, bytes ignored, no start.
        s0 = start_cnt;
        bus.cs_active = 1'b1;
        tick();
        send_byte(8'h0F);
        check("err tx", 64'(bus.tx_byte), 64'hEE);
        check("err busy", 64'(bus.busy), 64'd1);
        for (int k = 0; k < 8; k++) send_byte(8'h40);
        ack();
        check("err tx_hold", 64'(bus.tx_byte), 64'hEE);
        check("err no_start", 64'(start_cnt - s0), 64'd0);
        bus.cs_active = 1'b0;
        tick();
        check("err idle_tx", 64'(bus.tx_byte), 64'h00);
        check("err idle_busy", 64'(bus.busy), 64'd0);

        // Abort in WAIT, with a tx_ack during WAIT first.
        load_frame(10, vecs[0]);
        ack();
        check("wait ack_tx", 64'(bus.tx_byte), 64'h00);
        a0 = abort_cnt;
        bus.cs_active = 1'b0;
        tick();
        check("abort pulse", 64'(bus.fpu_abort), 64'd1);
        check("abort busy", 64'(bus.busy), 64'd0);
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h12345678;
        tick();
        bus.fpu_done = 1'b0;
        check("abort pulse_end", 64'(bus.fpu_abort), 64'd0);
        check("abort done_ignored", 64'(bus.tx_byte), 64'h00);
        check("abort count", 64'(abort_cnt - a0), 64'd1);
        tick();
        check("abort stay_idle", 64'(bus.busy), 64'd0);

        // cs drop coinciding with the last B byte: no start.
        s0 = start_cnt;
        bus.cs_active = 1'b1;
        tick();
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(8'h11);
        for (int k = 0; k < 3; k++) send_byte(8'h22);
        bus.cs_active = 1'b0;
        send_byte(8'h22);
        check("race start", 64'(bus.fpu_start), 64'd0);
        check("race busy", 64'(bus.busy), 64'd0);
        tick();
        tick();
        check("race no_start", 64'(start_cnt - s0), 64'd0);

        // Async reset in SEND, between clock edges.
        load_frame(11, vecs[2]);
        tick();
        bus.fpu_done   = 1'b1;
        bus.fpu_result = vecs[2].res;
        bus.fpu_flags  = 5'h00;
        tick();
        bus.fpu_done = 1'b0;
        ack();
        check("pre_rst tx", 64'(bus.tx_byte), 64'h40);
        #2;
        rst = 1'b1;
        #1;
        check("arst tx", 64'(bus.tx_byte), 64'h00);
        check("arst busy", 64'(bus.busy), 64'd0);
        check("arst op", 64'(bus.fpu_op), 64'd0);
        check("arst a", 64'(bus.fpu_a), 64'd0);
        check("arst b", 64'(bus.fpu_b), 64'd0);
        check("arst abort", 64'(bus.fpu_abort), 64'd0);
        bus.cs_active = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        load_frame(12, vecs[0]);
        finish_frame(12, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
